// File: rtl/pcs_pkg.sv
// pcs_pkg: 1000BASE-X PCS definitions shared by the transmit ordered-set generator
// and the receive synchroniser (code-group constants and state enums).
package pcs_pkg;

    localparam logic [7:0] K28_5  = 8'hBC;
    localparam logic [7:0] K_SOP  = 8'hFB;
    localparam logic [7:0] K_EOP  = 8'hFD;
    localparam logic [7:0] K_CARR = 8'hF7;
    localparam logic [7:0] K_ERR  = 8'hFE;
    localparam logic [7:0] D16_2  = 8'h50;
    localparam logic [7:0] D5_6   = 8'hC5;

    // Each tx state names the code group currently on xcvr_txd.
    typedef enum logic [2:0] {
        TX_IDLE_K,
        TX_IDLE_D,
        TX_SOP,
        TX_DATA,
        TX_EOP_T,
        TX_EOP_R,
        TX_EOP_R_ALIGN,
        TX_EXTEND
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_LOSS_OF_SYNC,
        RX_COMMA_DETECT,
        RX_ACQUIRE_SYNC,
        RX_SYNC_ACQUIRED
    } rx_sync_state_e;

    function automatic logic tx_state_busy(input tx_state_e s);
        return !(s == TX_IDLE_K || s == TX_IDLE_D);
    endfunction

endpackage

// File: rtl/pcs_tx_counters.sv
// pcs_tx_counters: saturating frame-completed and frame-aborted counters for the
// PCS transmit path, each advanced by a single-cycle increment strobe.
module pcs_tx_counters
    import pcs_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             frame_inc,
    input  logic             abort_inc,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] abort_cnt
);

    logic [CNT_W-1:0] frame_q, frame_d;
    logic [CNT_W-1:0] abort_q, abort_d;

    always_comb begin
        frame_d = frame_q;
        abort_d = abort_q;
        if (frame_inc && frame_q != '1) begin
            frame_d = frame_q + 1'b1;
        end
        if (abort_inc && abort_q != '1) begin
            abort_d = abort_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_q <= '0;
            abort_q <= '0;
        end else begin
            frame_q <= frame_d;
            abort_q <= abort_d;
        end
    end

    assign frame_cnt = frame_q;
    assign abort_cnt = abort_q;

endmodule

// File: rtl/pcs_tx_ordered_set.sv
// pcs_tx_ordered_set: 1000BASE-X PCS transmit ordered-set generator, GMII bytes in,
// code group + K flag out. Define PCS_TX_CARRIER_EXT_EN for carrier extension and /I1/ fix-up.
module pcs_tx_ordered_set
    import pcs_pkg::*;
#(
    parameter int         CNT_W      = 16,
    parameter logic [7:0] IDLE_D     = D16_2,
    parameter logic [7:0] IDLE_D_FIX = D5_6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       mac_txd,
    input  logic             mac_tx_en,
    input  logic             mac_tx_er,
    input  logic             xcvr_tx_ready,
    output logic [7:0]       xcvr_txd,
    output logic             xcvr_tx_datak,
    output logic             tx_even,
    output logic             tx_busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] abort_cnt
);

    tx_state_e  state_q, state_d;
    logic [7:0] txd_q, txd_d;
    logic       datak_q, datak_d;
    logic       even_q, even_d;
    logic       pend_q, pend_d;
    logic       hold_q, hold_d;
    logic       fix_q, fix_d;
    logic       sop_ok;
    logic       frame_inc, abort_inc;
`ifdef PCS_TX_CARRIER_EXT_EN
    localparam logic [7:0] CARR_EXT_TXD = 8'h0F;
    logic       ext_q, ext_d;
`endif

    // hold_q: tx_en has stayed high since the transceiver dropped ready, so that frame stays suppressed.
    always_comb begin
        state_d   = state_q;
        even_d    = ~even_q;
        pend_d    = 1'b0;
        hold_d    = mac_tx_en & (hold_q | ~xcvr_tx_ready);
        sop_ok    = mac_tx_en & ~hold_q;
        frame_inc = 1'b0;
        abort_inc = 1'b0;
`ifdef PCS_TX_CARRIER_EXT_EN
        ext_d     = 1'b0;
`endif
        if (!xcvr_tx_ready) begin
            abort_inc = tx_state_busy(state_q);
            state_d   = even_q ? TX_IDLE_D : TX_IDLE_K;
        end else begin
            case (state_q)
                TX_IDLE_K: begin
                    state_d = TX_IDLE_D;
                    pend_d  = sop_ok;
                end
                TX_IDLE_D: begin
                    state_d = (sop_ok || pend_q) ? TX_SOP : TX_IDLE_K;
                end
                TX_SOP, TX_DATA: begin
                    if (mac_tx_en) begin
                        state_d = TX_DATA;
                    end else begin
                        state_d   = TX_EOP_T;
                        frame_inc = 1'b1;
`ifdef PCS_TX_CARRIER_EXT_EN
                        ext_d     = mac_tx_er && (mac_txd == CARR_EXT_TXD);
`endif
                    end
                end
                TX_EOP_T: begin
`ifdef PCS_TX_CARRIER_EXT_EN
                    state_d = (ext_q && !mac_tx_en && mac_tx_er) ? TX_EXTEND : TX_EOP_R;
`else
                    state_d = TX_EOP_R;
`endif
                end
`ifdef PCS_TX_CARRIER_EXT_EN
                TX_EXTEND: begin
                    state_d = (!mac_tx_en && mac_tx_er) ? TX_EXTEND : TX_EOP_R;
                end
`endif
                TX_EOP_R: begin
                    state_d = even_q ? TX_EOP_R_ALIGN : TX_IDLE_K;
                end
                default: begin
                    state_d = TX_IDLE_K;
                end
            endcase
        end
    end

    // The code group is a pure decode of the next state, so it registers alongside it.
    always_comb begin
        txd_d   = K28_5;
        datak_d = 1'b1;
        fix_d   = 1'b0;
        case (state_d)
            TX_IDLE_D: begin
                txd_d   = fix_q ? IDLE_D_FIX : IDLE_D;
                datak_d = 1'b0;
            end
            TX_SOP: txd_d = K_SOP;
            TX_DATA: begin
                txd_d   = mac_tx_er ? K_ERR : mac_txd;
                datak_d = mac_tx_er;
            end
            TX_EOP_T: txd_d = K_EOP;
            TX_EOP_R, TX_EOP_R_ALIGN: txd_d = K_CARR;
`ifdef PCS_TX_CARRIER_EXT_EN
            TX_EXTEND: txd_d = (mac_txd == CARR_EXT_TXD) ? K_CARR : K_ERR;
`endif
            default: ;
        endcase
`ifdef PCS_TX_CARRIER_EXT_EN
        if (state_d == TX_EOP_R) begin
            fix_d = 1'b1;
        end else if (state_d != TX_IDLE_D) begin
            fix_d = fix_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= TX_IDLE_K;
            txd_q   <= K28_5;
            datak_q <= 1'b1;
            even_q  <= 1'b1;
            pend_q  <= 1'b0;
            hold_q  <= 1'b0;
            fix_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            txd_q   <= txd_d;
            datak_q <= datak_d;
            even_q  <= even_d;
            pend_q  <= pend_d;
            hold_q  <= hold_d;
            fix_q   <= fix_d;
        end
    end

`ifdef PCS_TX_CARRIER_EXT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ext_q <= 1'b0;
        end else begin
            ext_q <= ext_d;
        end
    end
`endif

    pcs_tx_counters #(.CNT_W(CNT_W)) u_counters (
        .clk       (clk),
        .reset_n   (reset_n),
        .frame_inc (frame_inc),
        .abort_inc (abort_inc),
        .frame_cnt (frame_cnt),
        .abort_cnt (abort_cnt)
    );

    assign xcvr_txd      = txd_q;
    assign xcvr_tx_datak = datak_q;
    assign tx_even       = even_q;
    assign tx_busy       = tx_state_busy(state_q);

endmodule
